id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
Pipeline hazard controller that sequences the decode stage and its neighbours. It generates the decode-stage pause (drives ID pause_i), fetch stall, and ID/EX bubble/flush controls. Inputs are load-use hazards, data-cache misses, taken branches/jumps and instruction-cache misses. It sits beside ID, consumes the ID register-address outputs and the EX-stage destination info, and contains a small FSM, a stall/flush cycle counter, a memory-wait watchdog and a saturating stall performance counter.

Parameters:
FLUSH_CYCLES, 2, total cycles flush_id_o/flush_ex_o stay high after a taken branch (>=1)
LU_STALL, 1, decode pause cycles inserted per load-use hazard (>=1)
MEM_TIMEOUT, 256, max cycles in MEM_WAIT before watchdog fires (>=2)
CNT_WIDTH, 16, width of stall performance counter

Ports:
clk_sys_i  in  1  system clock; all state updates on rising edge
rst_sys_i  in  1  synchronous active-high reset
id_rst1_addr_i  in  5  rs1 address of instruction in ID
id_rst2_addr_i  in  5  rs2 address of instruction in ID
id_use_rst1_i  in  1  ID instruction reads rs1
id_use_rst2_i  in  1  ID instruction reads rs2
ex_valid_i  in  1  EX stage holds a valid instruction
ex_is_load_i  in  1  EX instruction is a load
ex_rd_i  in  5  EX destination register
branch_taken_i  in  1  EX resolved taken branch/JAL/JALR (1-cycle pulse)
dcache_miss_i  in  1  data cache miss, level-held until refill done
icache_miss_i  in  1  instruction cache miss, level-held
pause_o  out  1  hold ID (to ID pause_i)
stall_if_o  out  1  hold PC/fetch
flush_id_o  out  1  invalidate instruction in IF/ID
flush_ex_o  out  1  inject bubble into ID/EX
timeout_o  out  1  one-cycle pulse: MEM_WAIT watchdog expired
state_o  out  2  current FSM state (debug)
stall_cnt_o  out  CNT_WIDTH  saturating count of cycles with pause_o=1

Behaviour:
- Hazard term: lu_hit = ex_valid_i & ex_is_load_i & (ex_rd_i!=0) & ((id_use_rst1_i & id_rst1_addr_i==ex_rd_i) | (id_use_rst2_i & id_rst2_addr_i==ex_rd_i)).
- pause_o/stall_if_o/flush_id_o/flush_ex_o are combinational from state, counter and current inputs (same-cycle response). State, counters, timeout_o and stall_cnt_o are registered.
- States: RUN=0, LOAD_USE=1, MEM_WAIT=2, FLUSH=3. Internal counter cnt, width ceil(log2(max(FLUSH_CYCLES,LU_STALL,MEM_TIMEOUT)))+1.
- RUN, evaluated in priority order:
  - branch_taken_i: flush_id_o=flush_ex_o=1; if FLUSH_CYCLES>1 go FLUSH with cnt=1, else stay RUN.
  - dcache_miss_i: pause_o=stall_if_o=1; go MEM_WAIT with cnt=0.
  - lu_hit: pause_o=stall_if_o=flush_ex_o=1; if LU_STALL>1 go LOAD_USE with cnt=1, else stay RUN.
  - icache_miss_i: stall_if_o=flush_ex_o=1, pause_o=0; stay RUN.
  - otherwise: all controls 0.
- LOAD_USE: pause_o=stall_if_o=flush_ex_o=1; cnt++. At cnt==LU_STALL-1, return RUN.
  - branch_taken_i overrides: enter FLUSH handling as in RUN.
  - dcache_miss_i overrides: enter MEM_WAIT handling as in RUN.
- MEM_WAIT: pause_o=stall_if_o=1, flush_ex_o=0; cnt++ each cycle.
  - dcache_miss_i low: go RUN next cycle (controls 0 in that cycle).
  - cnt==MEM_TIMEOUT-1 while still missing: timeout_o=1 next cycle; go FLUSH with cnt=0.
  - branch_taken_i is ignored here (EX is frozen).
- FLUSH: flush_id_o=flush_ex_o=1, pause_o=stall_if_o=0; cnt++. At cnt==FLUSH_CYCLES-1, return RUN.
  - A new branch_taken_i restarts cnt=1.
  - dcache_miss_i in FLUSH is deferred until RUN.
- Within one cycle branch_taken_i beats dcache_miss_i beats lu_hit beats icache_miss_i. Lower-priority events are not latched; they are re-evaluated from live inputs.
- stall_cnt_o increments each cycle pause_o=1 and saturates at all-ones.
- Reset (rst_sys_i=1 at an edge):
  - next state RUN, cnt=0, timeout_o=0, stall_cnt_o=0.
  - While rst_sys_i is high, all combinational controls are forced 0 regardless of inputs.
  - Reset mid-stall or mid-flush abandons the sequence.
- ex_rd_i==0 never causes a hazard. id_use_*=0 masks the matching compare.

Test Plan:
- Load-use, LU_STALL=1: ex_valid=1, ex_is_load=1, ex_rd=5, id_rst1=5, use1=1 in RUN -> pause_o=stall_if_o=flush_ex_o=1 for exactly 1 cycle; next cycle (EX bubble) all 0; stall_cnt_o=1.
- x0 and mask: same as above with ex_rd=0, or with use1=0 -> no stall, all controls 0.
- D-cache miss of 10 cycles: dcache_miss high cycles 0–9 -> pause_o=stall_if_o=1 cycles 0–9 (and cycle 10 reads RUN with 0), state_o=2 cycles 1–10, stall_cnt_o=10.
- Watchdog, MEM_TIMEOUT=4: dcache_miss held high -> timeout_o pulses once on the 5th cycle after entry, state_o=3 for FLUSH_CYCLES, then RUN with controls 0 even though miss is still high (then re-enters MEM_WAIT).
- Branch, FLUSH_CYCLES=2: branch_taken pulse while lu_hit and dcache_miss are also true -> flush_id_o=flush_ex_o=1 for 2 cycles, pause_o=0; a second branch on the 2nd flush cycle extends flush by one more cycle.
- Reset mid-MEM_WAIT: assert rst_sys_i for 1 cycle at cnt=3 -> all outputs 0 during reset, state_o=0, stall_cnt_o=0 the following cycle.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard sequencer: turns load-use, D/I-cache misses and taken
// branches into ID pause, fetch stall and IF/ID / ID/EX flush controls.
module id_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int LU_STALL     = 1,
    parameter int MEM_TIMEOUT  = 256,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic [4:0]           id_rst1_addr_i,
    input  logic [4:0]           id_rst2_addr_i,
    input  logic                 id_use_rst1_i,
    input  logic                 id_use_rst2_i,
    input  logic                 ex_valid_i,
    input  logic                 ex_is_load_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 branch_taken_i,
    input  logic                 dcache_miss_i,
    input  logic                 icache_miss_i,
    output logic                 pause_o,
    output logic                 stall_if_o,
    output logic                 flush_id_o,
    output logic                 flush_ex_o,
    output logic                 timeout_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int MAX_FL_LU = (FLUSH_CYCLES > LU_STALL) ? FLUSH_CYCLES : LU_STALL;
    localparam int MAX_CYC   = (MAX_FL_LU > MEM_TIMEOUT) ? MAX_FL_LU : MEM_TIMEOUT;
    localparam int CW        = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] LU_LAST = CW'(LU_STALL - 1);
    localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   timeout_reg, timeout_next;
    logic [CNT_WIDTH-1:0]   stall_cnt_reg;
    logic                   lu_hit;
    logic                   pause, stall_if, flush_id, flush_ex;

    assign lu_hit = ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                    ((id_use_rst1_i & (id_rst1_addr_i == ex_rd_i)) |
                     (id_use_rst2_i & (id_rst2_addr_i == ex_rd_i)));

    always_comb begin
        pause        = 1'b0;
        stall_if     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;

        case (state_reg)
            RUN, LOAD_USE: begin
                if (branch_taken_i) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = FLUSH;
                        cnt_next   = CNT_ONE;
                    end else begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end
                end else if (dcache_miss_i) begin
                    pause      = 1'b1;
                    stall_if   = 1'b1;
                    state_next = MEM_WAIT;
                    cnt_next   = '0;
                end else if (state_reg == LOAD_USE) begin
                    pause    = 1'b1;
                    stall_if = 1'b1;
                    flush_ex = 1'b1;
                    if (cnt_reg == LU_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end else if (lu_hit) begin
                    pause    = 1'b1;
                    stall_if = 1'b1;
                    flush_ex = 1'b1;
                    if (LU_STALL > 1) begin
                        state_next = LOAD_USE;
                        cnt_next   = CNT_ONE;
                    end
                end else if (icache_miss_i) begin
                    stall_if = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX is frozen while waiting, so a branch here cannot be real.
                if (!dcache_miss_i) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    pause    = 1'b1;
                    stall_if = 1'b1;
                    if (cnt_reg == TO_LAST) begin
                        timeout_next = 1'b1;
                        state_next   = FLUSH;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end
            default: begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
                if (branch_taken_i && (FLUSH_CYCLES > 1)) begin
                    cnt_next = CNT_ONE;
                end else if (cnt_reg == FL_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
        endcase

        if (rst_sys_i) begin
            pause    = 1'b0;
            stall_if = 1'b0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
            if (pause && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pause_o     = pause;
    assign stall_if_o  = stall_if;
    assign flush_id_o  = flush_id;
    assign flush_ex_o  = flush_ex;
    assign timeout_o   = timeout_reg;
    assign state_o     = state_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a countdown-style reference model.
module tb_id_hazard_ctrl;

    localparam int F   = 2;
    localparam int LU  = 2;
    localparam int TO  = 12;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    r1_addr, r2_addr, ex_rd;
    logic          use1, use2, ex_valid, ex_is_load;
    logic          br, dmiss, imiss;
    logic          pause, stall_if, flush_id, flush_ex, timeout;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_hazard_ctrl #(
        .FLUSH_CYCLES(F),
        .LU_STALL    (LU),
        .MEM_TIMEOUT (TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_sys_i     (clk),
        .rst_sys_i     (rst),
        .id_rst1_addr_i(r1_addr),
        .id_rst2_addr_i(r2_addr),
        .id_use_rst1_i (use1),
        .id_use_rst2_i (use2),
        .ex_valid_i    (ex_valid),
        .ex_is_load_i  (ex_is_load),
        .ex_rd_i       (ex_rd),
        .branch_taken_i(br),
        .dcache_miss_i (dmiss),
        .icache_miss_i (imiss),
        .pause_o       (pause),
        .stall_if_o    (stall_if),
        .flush_id_o    (flush_id),
        .flush_ex_o    (flush_ex),
        .timeout_o     (timeout),
        .state_o       (state),
        .stall_cnt_o   (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode number, cycles still to spend in LOAD_USE/FLUSH, cycles spent waiting.
    int m_state, m_left, m_wait, m_stalls;
    bit m_to;
    int n_state, n_left, n_wait, n_stalls;
    bit n_to;
    logic [12:0] exp_vec;

    function automatic logic [12:0] obs();
        return {pause, stall_if, flush_id, flush_ex, timeout, state, stall_cnt};
    endfunction

    task automatic apply(input bit r, input bit b, input bit d, input bit i,
                         input bit ev, input bit el, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input bit u1, input bit u2);
        bit lu, e_p, e_s, e_fi, e_fe;
        @(posedge clk);
        m_state = n_state; m_left = n_left; m_wait = n_wait;
        m_stalls = n_stalls; m_to = n_to;
        #1;
        rst = r; br = b; dmiss = d; imiss = i; ex_valid = ev; ex_is_load = el;
        ex_rd = rd; r1_addr = a1; r2_addr = a2; use1 = u1; use2 = u2;

        lu = ev && el && (rd != 0) && ((u1 && a1 == rd) || (u2 && a2 == rd));
        e_p = 0; e_s = 0; e_fi = 0; e_fe = 0;
        n_state = m_state; n_left = m_left; n_wait = m_wait; n_to = 0;
        if (r) begin
            n_state = 0; n_left = 0; n_wait = 0;
        end else begin
            case (m_state)
                0, 1: begin
                    if (b) begin
                        e_fi = 1; e_fe = 1;
                        n_left = F - 1;
                        n_state = (n_left > 0) ? 3 : 0;
                    end else if (d) begin
                        e_p = 1; e_s = 1;
                        n_state = 2; n_wait = 0;
                    end else if (m_state == 1) begin
                        e_p = 1; e_s = 1; e_fe = 1;
                        n_left = m_left - 1;
                        n_state = (n_left > 0) ? 1 : 0;
                    end else if (lu) begin
                        e_p = 1; e_s = 1; e_fe = 1;
                        n_left = LU - 1;
                        n_state = (n_left > 0) ? 1 : 0;
                    end else if (i) begin
                        e_s = 1; e_fe = 1;
                    end
                end
                2: begin
                    if (!d) begin
                        n_state = 0;
                    end else begin
                        e_p = 1; e_s = 1;
                        if (m_wait + 1 == TO) begin
                            n_to = 1; n_state = 3; n_left = F;
                        end else begin
                            n_wait = m_wait + 1;
                        end
                    end
                end
                default: begin
                    e_fi = 1; e_fe = 1;
                    n_left = b ? F - 1 : m_left - 1;
                    n_state = (n_left > 0) ? 3 : 0;
                end
            endcase
        end
        n_stalls = r ? 0 : ((e_p && m_stalls < SAT) ? m_stalls + 1 : m_stalls);
        exp_vec = {e_p, e_s, e_fi, e_fe, m_to, 2'(m_state), 6'(m_stalls)};
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1, 1, 1, 1, 1, 1, 5'd7, 5'd7, 5'd7, 1, 1);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL reset c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== 13'd0) begin
            errors++;
            $display("FAIL reset_idle got=%b want=%b", obs(), 13'd0);
        end
    endtask

    task automatic test_load_use();
        int np = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < LU) apply(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd9, 1, 0);
            else        apply(0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd9, 1, 0);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL load_use c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
            if (pause) np++;
        end
        checks++;
        if (np != LU || stall_cnt !== 6'(LU)) begin
            errors++;
            $display("FAIL load_use_len pauses=%0d cnt=%0d want=%0d", np, stall_cnt, LU);
        end
    endtask

    task automatic test_x0_mask();
        int np = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: apply(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1);
                1: apply(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd6, 0, 1);
                2: apply(0, 0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 1, 1);
                default: apply(0, 0, 0, 1, 1, 1, 5'd5, 5'd6, 5'd7, 1, 1);
            endcase
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL x0_mask c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
            if (pause) np++;
        end
        checks++;
        if (np != 0) begin
            errors++;
            $display("FAIL x0_mask_pause pauses=%0d want=0", np);
        end
    endtask

    task automatic test_dcache_miss();
        int np = 0, nw = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            apply(0, 0, (c < 10), 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL dmiss c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
            if (pause) np++;
            if (state == 2'd2) nw++;
        end
        checks++;
        if (np != 10 || nw != 10 || stall_cnt !== 6'd10) begin
            errors++;
            $display("FAIL dmiss_len pauses=%0d waits=%0d cnt=%0d want=10", np, nw, stall_cnt);
        end
    endtask

    task automatic test_watchdog();
        int nto = 0, tcyc = -1, nfl = 0;
        do_reset();
        for (int c = 0; c < TO + 6; c++) begin
            apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL watchdog c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
            if (timeout) begin nto++; tcyc = c; end
            if (state == 2'd3) nfl++;
        end
        checks++;
        if (nto != 1 || tcyc != TO + 1 || nfl != F) begin
            errors++;
            $display("FAIL watchdog_pulse pulses=%0d at=%0d flush=%0d want 1 at %0d flush %0d",
                     nto, tcyc, nfl, TO + 1, F);
        end
    endtask

    task automatic test_branch();
        int nf1 = 0, nf2 = 0, np = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: apply(0, 1, 1, 0, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
                4, 5: apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                default: apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL branch c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
            if (c < 4 && flush_id && flush_ex) nf1++;
            if (c >= 4 && flush_id && flush_ex) nf2++;
            if (pause) np++;
        end
        checks++;
        if (nf1 != F || nf2 != F + 1 || np != 0) begin
            errors++;
            $display("FAIL branch_len flush1=%0d flush2=%0d pauses=%0d want %0d %0d 0",
                     nf1, nf2, np, F, F + 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            apply((c == 4), 0, (c <= 4), 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL reset_wait c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
            if (c == 4) begin
                checks++;
                if ({pause, stall_if, flush_id, flush_ex} !== 4'b0) begin
                    errors++;
                    $display("FAIL reset_wait_ctrl got=%b want=0000",
                             {pause, stall_if, flush_id, flush_ex});
                end
            end
            if (c == 5) begin
                checks++;
                if (state !== 2'd0 || stall_cnt !== 6'd0) begin
                    errors++;
                    $display("FAIL reset_wait_after state=%0d cnt=%0d want 0 0", state, stall_cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        bit d = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) d = ~d;
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), d,
                  ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL random c=%0d got=%b want=%b", c, obs(), exp_vec);
            end
        end
    endtask

    initial begin
        rst = 1; br = 0; dmiss = 0; imiss = 0; ex_valid = 0; ex_is_load = 0;
        ex_rd = 0; r1_addr = 0; r2_addr = 0; use1 = 0; use2 = 0;
        repeat (2) @(posedge clk);
        n_state = 0; n_left = 0; n_wait = 0; n_stalls = 0; n_to = 0;
        test_reset();
        test_load_use();
        test_x0_mask();
        test_dcache_miss();
        test_watchdog();
        test_branch();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
